// File: rtl/hqc_rsdecod_ctrl_if.sv
// Link between the RS decode sequencer (master) and the HQC Reed-Solomon decoder core (slave).
interface hqc_rsdecod_ctrl_if #(
    parameter int PARAM_K = 16
);
    logic                 dec_start_o;
    logic [7:0]           dec_din_o;
    logic                 dec_din_valid_o;
    logic                 dec_din_done_o;
    logic                 dec_done_i;
    logic [8*PARAM_K-1:0] dec_msg_i;

    modport master (
        output dec_start_o, dec_din_o, dec_din_valid_o, dec_din_done_o,
        input  dec_done_i, dec_msg_i
    );

    modport slave (
        input  dec_start_o, dec_din_o, dec_din_valid_o, dec_din_done_o,
        output dec_done_i, dec_msg_i
    );
endinterface

// File: rtl/hqc_rsdecod_ctrl.sv
// Sequencer around the HQC RS decoder core: streams N1 codeword bytes in, holds the K-byte message out.
// Defining HQC_RSDEC_TIMEOUT_EN adds a watchdog that aborts a decode stuck waiting for the core.
module hqc_rsdecod_ctrl #(
    parameter int PARAM_SECURITY = 128,
    parameter int PARAM_K        = (PARAM_SECURITY == 128) ? 16 :
                                   (PARAM_SECURITY == 192) ? 24 :
                                   (PARAM_SECURITY == 256) ? 32 : 31,
    parameter int PARAM_N1       = (PARAM_SECURITY == 192) ? 56 :
                                   (PARAM_SECURITY == 256) ? 90 : 46,
    parameter int TIMEOUT_CYC    = 4095
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic [7:0]           cw_byte_i,
    input  logic                 cw_valid_i,
    output logic                 cw_ready_o,
    hqc_rsdecod_ctrl_if.master   dec_if,
    output logic [8*PARAM_K-1:0] msg_o,
    output logic                 msg_valid_o,
    input  logic                 msg_ready_i
);
    localparam logic [6:0] N1_C = 7'(PARAM_N1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_HOLD} state_e;

    state_e               state_q, state_d;
    logic [6:0]           cnt_q, cnt_d;
    logic                 dec_start_q, dec_start_d;
    logic [7:0]           din_q, din_d;
    logic                 din_valid_q, din_valid_d;
    logic                 din_done_q, din_done_d;
    logic [8*PARAM_K-1:0] msg_q, msg_d;
    logic                 msg_valid_q, msg_valid_d;
    logic                 done_q, done_d;
    logic                 cw_accept;
    logic                 timeout;

    assign cw_ready_o = (state_q == S_FEED) && (cnt_q < N1_C);
    assign cw_accept  = cw_ready_o && cw_valid_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_start_d = 1'b0;
        din_d       = din_q;
        din_valid_d = 1'b0;
        din_done_d  = 1'b0;
        msg_d       = msg_q;
        msg_valid_d = msg_valid_q;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_START;
                    dec_start_d = 1'b1;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (cw_accept) begin
                    din_d       = cw_byte_i;
                    din_valid_d = 1'b1;
                    cnt_d       = cnt_q + 7'd1;
                end
                // Last byte is on dec_din_o this cycle; the done marker follows it.
                if ((cnt_q == N1_C) && din_valid_q) begin
                    din_done_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dec_if.dec_done_i) begin
                    msg_d       = dec_if.dec_msg_i;
                    msg_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (msg_ready_i) begin
                    msg_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dec_start_q <= 1'b0;
            din_q       <= '0;
            din_valid_q <= 1'b0;
            din_done_q  <= 1'b0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_start_q <= dec_start_d;
            din_q       <= din_d;
            din_valid_q <= din_valid_d;
            din_done_q  <= din_done_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            done_q      <= done_d;
        end
    end

`ifdef HQC_RSDEC_TIMEOUT_EN
    logic [11:0] wd_q, wd_d;
    logic        err_q, err_d;

    // Counter reads zero on the first WAIT cycle, so the abort lands TIMEOUT_CYC cycles after entry.
    assign timeout = (state_q == S_WAIT) && (wd_q == 12'(TIMEOUT_CYC - 1));

    always_comb begin
        wd_d  = (state_q == S_WAIT) ? (wd_q + 12'd1) : 12'd0;
        err_d = timeout && !dec_if.dec_done_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
    assign err_o              = 1'b0;
`endif

    assign busy_o                 = (state_q != S_IDLE);
    assign done_o                 = done_q;
    assign msg_o                  = msg_q;
    assign msg_valid_o            = msg_valid_q;
    assign dec_if.dec_start_o     = dec_start_q;
    assign dec_if.dec_din_o       = din_q;
    assign dec_if.dec_din_valid_o = din_valid_q;
    assign dec_if.dec_din_done_o  = din_done_q;
endmodule

// File: tb/tb_hqc_rsdecod_ctrl.sv
// Self-checking bench for hqc_rsdecod_ctrl: vector table plus randomized decodes against a transaction-level model.
module tb_hqc_rsdecod_ctrl;
  localparam int SEC = 128;
  localparam int K   = 16;
  localparam int N1  = 46;
  localparam int TO  = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic           busy_o, done_o, err_o;
  logic [7:0]     cw_byte_i = 8'h00;
  logic           cw_valid_i = 1'b0;
  logic           cw_ready_o;
  logic [8*K-1:0] msg_o;
  logic           msg_valid_o;
  logic           msg_ready_i = 1'b0;

  hqc_rsdecod_ctrl_if #(.PARAM_K(K)) dec_if ();

  hqc_rsdecod_ctrl #(.PARAM_SECURITY(SEC), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cw_byte_i(cw_byte_i), .cw_valid_i(cw_valid_i), .cw_ready_o(cw_ready_o),
    .dec_if(dec_if), .msg_o(msg_o), .msg_valid_o(msg_valid_o), .msg_ready_i(msg_ready_i)
  );

  typedef struct {
    int mode;        // 0 continuous, 1 alternating 1010, 2 random gaps
    int dly;         // cycles msg_ready_i stays low after msg_valid_o
    int lat;         // core latency from din_done to done
    bit seq;         // bytes i / message i instead of random
    bit hold_start;  // pulse start_i while the message is held
    bit stray_feed;  // inject a stray core done during FEED
    int exp_fwd;     // bytes forwarded to the core
    int exp_hold;    // cycles msg_valid_o stays high
  } vec_t;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] src[$];
  logic [7:0] got[$];
  logic [7:0] exp_b[N1];
  logic [127:0] exp_msg = '0, last_msg = '0;
  int vmode = 0, ready_dly = 0, hold_n = 0, lat = 1, core_cnt = 0;
  bit phase = 1'b1, core_en = 1'b1, stray = 1'b0, start_hold = 1'b0;
  int n_start, n_done, n_dd, n_err, n_acc, n_hold, msg_bad, post_bad;
  int start_cyc, last_dv_cyc, dd_cyc, hs_cyc, done_cyc, err_cyc;

  task automatic check_i(input string name, input int got_v, input int exp_v);
    n_tests++;
    if (got_v != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got_v, exp_v);
    end
  endtask

  task automatic check_v(input string name, input logic [127:0] got_v, input logic [127:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got_v, exp_v);
    end
  endtask

  task automatic init_trans();
    n_start = 0; n_done = 0; n_dd = 0; n_err = 0; n_acc = 0; n_hold = 0;
    msg_bad = 0; post_bad = 0; start_cyc = -1; last_dv_cyc = -1; dd_cyc = -1;
    hs_cyc = -1; done_cyc = -1; err_cyc = -1; hold_n = 0; core_cnt = 0;
    got.delete(); src.delete();
  endtask

  task automatic fill_src(input bit seq);
    for (int i = 0; i < N1; i++) begin
      exp_b[i] = seq ? 8'(i) : 8'($urandom_range(0, 255));
      src.push_back(exp_b[i]);
    end
    src.push_back(8'hA5);
  endtask

  // One clock: drive inputs for this cycle, advance, then observe outputs 1ns after the edge.
  task automatic step();
    bit acc, hs;
    case (vmode)
      0:       cw_valid_i = 1'b1;
      1:       begin cw_valid_i = phase; phase = ~phase; end
      default: cw_valid_i = 1'($urandom_range(0, 1));
    endcase
    if (src.size() == 0) cw_valid_i = 1'b0;
    cw_byte_i = (src.size() > 0) ? src[0] : 8'h00;
    dec_if.dec_done_i = 1'b0;
    dec_if.dec_msg_i  = {$urandom, $urandom, $urandom, $urandom};
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        dec_if.dec_done_i = 1'b1;
        dec_if.dec_msg_i  = exp_msg;
      end
    end
    if (stray) begin
      dec_if.dec_done_i = 1'b1;
      stray = 1'b0;
    end
    if (msg_valid_o) begin
      msg_ready_i = (hold_n >= ready_dly);
      hold_n++;
    end else begin
      msg_ready_i = (ready_dly == 0);
    end
    if (start_hold) start_i = msg_valid_o;
    acc = cw_valid_i && cw_ready_o;
    hs  = msg_valid_o && msg_ready_i;
    if (hs) hs_cyc = cyc;
    @(posedge clk); #1; cyc++;
    if (acc) begin
      void'(src.pop_front());
      n_acc++;
      if (n_acc == N1) check_i("cw_ready_drop", int'(cw_ready_o), 0);
    end
    if (dec_if.dec_start_o) begin n_start++; start_cyc = cyc; end
    if (dec_if.dec_din_valid_o) begin got.push_back(dec_if.dec_din_o); last_dv_cyc = cyc; end
    if (dec_if.dec_din_done_o) begin n_dd++; dd_cyc = cyc; if (core_en) core_cnt = lat; end
    if (done_o) begin n_done++; done_cyc = cyc; if (busy_o || msg_valid_o) post_bad++; end
    if (err_o) begin n_err++; err_cyc = cyc; end
    if (msg_valid_o) begin n_hold++; if (msg_o !== exp_msg) msg_bad++; end
  endtask

  task automatic do_reset();
    #2 rst_ni = 1'b0;
    #1;
    check_i("rst_ctrl_outs", int'({busy_o, done_o, err_o, cw_ready_o, msg_valid_o}), 0);
    check_i("rst_dec_outs", int'({dec_if.dec_start_o, dec_if.dec_din_valid_o,
                                  dec_if.dec_din_done_o, dec_if.dec_din_o}), 0);
    check_v("rst_msg", msg_o, '0);
    start_i = 1'b0; stray = 1'b0; core_cnt = 0; start_hold = 1'b0;
    @(posedge clk); #1; cyc++;
    rst_ni = 1'b1;
    last_msg = '0;
  endtask

  task automatic run_decode(input vec_t v, input string tag);
    int s_cyc, bad;
    bit stray_done;
    init_trans();
    fill_src(v.seq);
    for (int i = 0; i < K; i++) exp_msg[8*i +: 8] = v.seq ? 8'(i) : 8'($urandom_range(0, 255));
    vmode = v.mode; phase = 1'b1; ready_dly = v.dly; lat = v.lat; core_en = 1'b1;
    stray_done = 1'b0;
    start_i = 1'b1; s_cyc = cyc;
    step();
    start_i = 1'b0;
    check_i({tag, "_done_width"}, int'(done_o), 0);
    check_i({tag, "_busy"}, int'(busy_o), 1);
    start_hold = v.hold_start;
    for (int i = 0; i < 3000 && n_done == 0; i++) begin
      if (v.stray_feed && !stray_done && n_acc == 10) begin
        stray = 1'b1; stray_done = 1'b1;
        step();
        check_i({tag, "_stray_valid"}, int'(msg_valid_o), 0);
        check_v({tag, "_stray_msg"}, msg_o, last_msg);
      end else begin
        step();
      end
    end
    start_hold = 1'b0; start_i = 1'b0;
    bad = 0;
    for (int i = 0; i < got.size() && i < N1; i++) if (got[i] !== exp_b[i]) bad++;
    check_i({tag, "_starts"}, n_start, 1);
    check_i({tag, "_start_lat"}, start_cyc - s_cyc, 1);
    check_i({tag, "_fwd_count"}, got.size(), v.exp_fwd);
    check_i({tag, "_byte_order"}, bad, 0);
    check_i({tag, "_extra_kept"}, src.size(), 1);
    check_i({tag, "_din_done"}, n_dd, 1);
    check_i({tag, "_din_done_gap"}, dd_cyc - last_dv_cyc, 1);
    check_i({tag, "_hold_cycles"}, n_hold, v.exp_hold);
    check_i({tag, "_msg_stable"}, msg_bad, 0);
    check_i({tag, "_done"}, n_done, 1);
    check_i({tag, "_done_gap"}, done_cyc - hs_cyc, 1);
    check_i({tag, "_idle_at_done"}, post_bad, 0);
    check_i({tag, "_err"}, n_err, 0);
    check_v({tag, "_msg_final"}, msg_o, exp_msg);
    last_msg = exp_msg;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{mode:0, dly:0,  lat:20, seq:1, hold_start:0, stray_feed:0, exp_fwd:N1, exp_hold:1};
    vecs[1] = '{mode:1, dly:0,  lat:5,  seq:0, hold_start:0, stray_feed:0, exp_fwd:N1, exp_hold:1};
    vecs[2] = '{mode:0, dly:10, lat:3,  seq:0, hold_start:1, stray_feed:0, exp_fwd:N1, exp_hold:11};
    vecs[3] = '{mode:2, dly:0,  lat:1,  seq:0, hold_start:0, stray_feed:1, exp_fwd:N1, exp_hold:1};
    for (int i = 4; i < 10; i++) begin
      vecs[i].mode       = $urandom_range(0, 2);
      vecs[i].dly        = $urandom_range(0, 6);
      vecs[i].lat        = $urandom_range(1, 30);
      vecs[i].seq        = 1'b0;
      vecs[i].hold_start = 1'($urandom_range(0, 1));
      vecs[i].stray_feed = 1'($urandom_range(0, 1));
      vecs[i].exp_fwd    = N1;
      vecs[i].exp_hold   = vecs[i].dly + 1;
    end

    dec_if.dec_done_i = 1'b0;
    dec_if.dec_msg_i  = '0;
    @(posedge clk); #1;
    do_reset();

    // Idle: offered bytes are left alone, a stray core done is ignored.
    init_trans();
    fill_src(1'b1);
    vmode = 0; ready_dly = 0;
    for (int i = 0; i < 3; i++) step();
    check_i("idle_ready", int'(cw_ready_o), 0);
    check_i("idle_not_consumed", src.size(), N1 + 1);
    check_i("idle_no_fwd", got.size(), 0);
    stray = 1'b1;
    step();
    check_i("idle_stray_valid", int'(msg_valid_o), 0);
    check_v("idle_stray_msg", msg_o, last_msg);

    for (int i = 0; i < 10; i++) run_decode(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of FEED, then a clean decode from count zero.
    init_trans();
    fill_src(1'b0);
    vmode = 0;
    start_i = 1'b1; step(); start_i = 1'b0;
    for (int i = 0; i < 200 && n_acc < 20; i++) step();
    check_i("midfeed_busy", int'(busy_o), 1);
    do_reset();
    run_decode(vecs[0], "after_rst");

    // Core never answers.
    init_trans();
    fill_src(1'b0);
    vmode = 0; core_en = 1'b0;
    start_i = 1'b1; step(); start_i = 1'b0;
    for (int i = 0; i < 400 && n_dd == 0; i++) step();
    check_i("to_din_done", n_dd, 1);
`ifdef HQC_RSDEC_TIMEOUT_EN
    for (int i = 0; i < 4 * TO && n_err == 0; i++) step();
    check_i("to_err_seen", n_err, 1);
    check_i("to_err_latency", err_cyc - dd_cyc, TO);
    check_i("to_busy_low", int'(busy_o), 0);
    for (int i = 0; i < 5; i++) step();
    check_i("to_err_width", n_err, 1);
    check_i("to_no_restart", n_start, 1);
    check_i("to_no_msg", n_hold, 0);
`else
    for (int i = 0; i < 2 * TO; i++) step();
    check_i("nto_busy_high", int'(busy_o), 1);
    check_i("nto_no_err", n_err, 0);
    check_i("nto_no_msg", n_hold, 0);
`endif
    core_en = 1'b1;
    do_reset();
    run_decode(vecs[4], "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hqc_rsdecod_ctrl.md
Name: hqc_rsdecod_ctrl

Overview:
Sequencer that wraps the HQC Reed-Solomon decoder core for one decapsulation.
- Accepts a decode request and pulls PARAM_N1 codeword bytes from an upstream byte stream (valid/ready); the upstream is the RM decoder output.
- Drives the RS decoder's start/din/din_valid/din_done pins, waits for its done, and captures the corrected message.
- Presents the message downstream with a valid/ready hold, so the decoder can be started again only after the message has been consumed.

Parameters:
PARAM_SECURITY, 128, security level; selects K/N1 (128: K=16 N1=46; 192: K=24 N1=56; 256: K=32 N1=90; other: K=31 N1=46)
PARAM_K, derived from PARAM_SECURITY, message bytes
PARAM_N1, derived from PARAM_SECURITY, codeword bytes
TIMEOUT_CYC, 4095, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assert, active-low
start_i  in  1  decode request pulse; honoured only in IDLE
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when the message is accepted downstream
err_o  out  1  one-cycle pulse on watchdog abort (tied 0 without the macro)
cw_byte_i  in  8  codeword byte, first byte = c[0]
cw_valid_i  in  1  upstream byte valid
cw_ready_o  out  1  ctrl can accept a byte
dec_start_o  out  1  start pulse to the RS decoder
dec_din_o  out  8  byte to the RS decoder
dec_din_valid_o  out  1  dec_din_o valid
dec_din_done_o  out  1  last-byte marker pulse
dec_done_i  in  1  RS decoder done pulse
dec_msg_i  in  8*PARAM_K  corrected message, valid on dec_done_i
msg_o  out  8*PARAM_K  held message {m[K-1]..m[0]}
msg_valid_o  out  1  msg_o valid
msg_ready_i  in  1  downstream accepts msg_o

Behaviour:
Reset (async, rst_ni=0):
- State = IDLE, byte count = 0.
- All outputs = 0, including msg_o.

State IDLE:
- start_i=1 -> START. Otherwise stay.
- cw_ready_o=0; upstream bytes presented here are not consumed.

State START (exactly 1 cycle):
- dec_start_o=1 registered, i.e. high in the cycle after the state is entered.
- Byte count cleared. Next state FEED.

State FEED:
- cw_ready_o = 1 while count < N1.
- Byte accepted on cw_valid_i & cw_ready_o. Next cycle: dec_din_o = byte, dec_din_valid_o = 1 (registered, 1-cycle latency). Count += 1.
- Gaps in cw_valid_i produce gaps in dec_din_valid_o; bytes are never reordered.
- On acceptance of byte N1-1: cw_ready_o drops in the following cycle.
- dec_din_done_o pulses 1 cycle after the last dec_din_valid_o. Same cycle -> WAIT.
- Count is 7 bits and never exceeds N1. No byte beyond N1 is consumed.

State WAIT:
- Waits for dec_done_i.
- On dec_done_i: msg_o <= dec_msg_i, msg_valid_o <= 1 -> HOLD.
- dec_done_i in any other state is ignored, and msg_o is unchanged.

State HOLD:
- msg_valid_o=1; msg_o is stable.
- On msg_valid_o & msg_ready_i: msg_valid_o <= 0, done_o pulses the next cycle -> IDLE.
- If msg_ready_i is already high on HOLD entry, the transfer completes in the first HOLD cycle.

Simultaneous events and restarts:
- start_i outside IDLE is ignored; no queuing.
- start_i in the IDLE cycle where done_o pulses is honoured.
- Back-to-back decodes: minimum IDLE dwell is 1 cycle.
- Asynchronous reset mid-operation aborts immediately, with outputs to reset values. The decoder core is reset by the same rst_ni.

Optional Feature:
Macro HQC_RSDEC_TIMEOUT_EN.
- Defined:
  - A 12-bit watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without dec_done_i: err_o pulses 1 cycle, msg_valid_o stays 0, state -> IDLE, and dec_start_o is not reissued.
  - dec_done_i in the same cycle as the timeout wins (normal completion).
- Not defined: no counter logic, err_o tied 0, WAIT is unbounded.

Test Plan:
1. Basic decode (PARAM_SECURITY=128), continuous stimulus: reset, start_i, 46 contiguous bytes 0x00..0x2D; dec model returns done 20 cycles after din_done with msg 0x0F..0x00; msg_ready_i=1 -> exactly one dec_start_o, 46 dec_din_valid_o carrying bytes in order, dec_din_done_o 1 cycle after the 46th, msg_o=0x0F0E..00, done_o 1 cycle after HOLD.
2. Bubbles: cw_valid_i toggled 1010... -> 46 bytes forwarded in order; cw_ready_o=0 after the 46th; a 47th valid byte is not consumed.
3. Backpressure: msg_ready_i=0 for 10 cycles after msg_valid_o, then 1 -> msg_o stable for all 11 cycles; done_o single pulse; start_i during HOLD ignored (no dec_start_o).
4. Reset mid-FEED: rst_ni low after byte 20 -> all outputs 0 asynchronously; a new start_i then feeds 46 bytes from count 0.
5. Timeout (macro defined, TIMEOUT_CYC=100): dec_done_i never asserted -> err_o pulses 100 cycles after WAIT entry, busy_o falls, msg_valid_o stays 0; without the macro, busy_o stays high.
6. Stray done: dec_done_i pulsed in IDLE and in FEED -> no msg_valid_o, msg_o unchanged.
